iopage_bus: RTL and testbench
=============================

IOPAGE_BUS -- requirements
Module: iopage_bus

Interface
REQ-001 SHALL have parameter NDEV, default 8: number of I/O page device slots, range 1..16.
REQ-002 SHALL have parameter TIMEOUT, default 4: cycles of undecoded access before no_decode, range 2..15.
REQ-003 SHALL have parameter DEFAULT_DATA, default 16'h0000: data_out value when no slot decodes.
REQ-004 SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- iopage_rd  in  1  CPU I/O page read strobe.
- iopage_wr  in  1  CPU I/O page write strobe.
- dev_decode  in  NDEV  per-slot address decode.
- dev_data_out  in  16*NDEV  per-slot read data; slot i occupies bits [16i+15:16i].
- dev_interrupt  in  NDEV  per-slot interrupt request level.
- dev_ipl  in  3*NDEV  per-slot request priority, 4..7.
- dev_vector  in  8*NDEV  per-slot vector.
- dev_interrupt_ack  out  NDEV  one-cycle grant pulse to a slot.
- cpu_pri  in  3  current CPU priority, PSW[7:5].
- ack_ipl  in  8  CPU interrupt acknowledge, one-hot by level.
- data_out  out  16  muxed read data.
- no_decode  out  1  bus-timeout pulse.
- decode_err  out  1  sticky flag: more than one slot decoded.
- interrupt  out  1  request to CPU.
- interrupt_ipl  out  8  one-hot level of the presented request.
- vector  out  8  vector of the presented request.

Function
REQ-005 data_out SHALL be combinational: dev_data_out of the lowest-index asserted dev_decode bit, else DEFAULT_DATA.
REQ-006 decode_err SHALL set on any cycle where two or more dev_decode bits are asserted and (iopage_rd|iopage_wr) is high, and SHALL clear only on reset.
REQ-007 A timeout counter SHALL increment each cycle that (iopage_rd|iopage_wr) is high and dev_decode is zero, and SHALL clear on any other cycle.
REQ-008 no_decode SHALL be registered and SHALL pulse for exactly one cycle, the cycle after the counter reaches TIMEOUT-1; the counter SHALL saturate so there is no repeat pulse while the strobe stays high.
REQ-009 The counter SHALL clear with no pulse if a decode appears, or the strobe drops, before the count reaches TIMEOUT-1.
REQ-010 The arbiter FSM SHALL have states IDLE, PRESENT, and RELEASE.
REQ-011 IDLE: among slots with dev_interrupt=1 and dev_ipl>cpu_pri, select the highest ipl, with ties going to the lowest index. If a candidate exists, latch win_idx, win_ipl, and win_vec and go to PRESENT.
REQ-012 PRESENT SHALL drive interrupt=1, interrupt_ipl[win_ipl]=1 with all other bits 0, and vector=win_vec. All three SHALL be registered and valid in the first PRESENT cycle.
REQ-013 PRESENT with ack_ipl[win_ipl]=1: pulse dev_interrupt_ack[win_idx] for one cycle and go to RELEASE.
REQ-014 PRESENT, no ack, with dev_interrupt[win_idx]=0 or cpu_pri>=win_ipl: withdraw, return to IDLE, and drop interrupt the next cycle.
REQ-015 Ack SHALL take precedence over withdrawal on the same cycle.
REQ-016 No preemption: a higher-priority request arriving in PRESENT SHALL wait for IDLE re-arbitration.
REQ-017 RELEASE SHALL drive interrupt=0 and SHALL stay until dev_interrupt[win_idx]=0, then go to IDLE.
REQ-018 The minimum gap between successive presentations SHALL be one IDLE cycle.
REQ-019 ack_ipl bits other than win_ipl, and any ack_ipl asserted in IDLE or RELEASE, SHALL be ignored.
REQ-020 The data/timeout path and the interrupt path SHALL be independent and SHALL operate concurrently.

Reset
REQ-021 While reset=1 at a clk edge, the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-022 Reset values SHALL be: no_decode=0, decode_err=0, interrupt=0, interrupt_ipl=0, vector=0, dev_interrupt_ack=0.
REQ-023 Reset asserted in PRESENT or RELEASE SHALL abandon the grant with no ack pulse.

Structure
REQ-024 Shared include iopage_defs.vh SHALL hold the FSM state encodings, IPL_MIN=4, and the default parameter values.
REQ-025 Sub-module iopage_prio_enc SHALL be combinational and parametrised by NDEV. It takes qualified requests plus ipls and returns found, index, and ipl.
REQ-026 All state SHALL be in a single clk domain, with no latches.

Verification
REQ-027 Read with dev_decode=8'b0000_0100 and slot 2 data=16'o173000 -> data_out=16'o173000 in the same cycle; no_decode stays 0.
REQ-028 iopage_rd held 6 cycles with dev_decode=0, TIMEOUT=4 -> exactly one no_decode pulse, in cycle 5; a re-strobe produces a new pulse.
REQ-029 Slots 1 (ipl 5, vec 0o220) and 3 (ipl 6, vec 0o100) request with cpu_pri=0 -> vector=0o100, interrupt_ipl=8'h40; ack_ipl=8'h40 -> one-cycle dev_interrupt_ack[3].
REQ-030 Two slots at ipl 4, cpu_pri=4 -> interrupt stays 0; cpu_pri drops to 3 -> the lower-index slot is presented.
REQ-031 Slot 0 presented, then dev_interrupt[0] drops before ack -> interrupt=0 next cycle, no ack pulse; dev_decode=8'b0000_0011 with rd -> decode_err=1 persists.
REQ-032 reset pulsed in PRESENT -> all outputs take their reset values the next cycle, with no ack pulse.

Source files
------------

// File: rtl/iopage_bus_pkg.sv
// Shared definitions for the I/O page bus block: default parameter values,
// the lowest valid device interrupt priority, the slot-index and
// timeout-counter widths, and the interrupt arbiter state encoding.
package iopage_bus_pkg;

    localparam int          DEF_NDEV    = 8;
    localparam int          DEF_TIMEOUT = 4;
    localparam logic [15:0] DEF_DATA    = 16'h0000;

    // Devices request at levels 4..7; lower levels belong to the CPU itself.
    localparam int          IPL_MIN     = 4;

    // Wide enough for up to 16 slots and a TIMEOUT of up to 15.
    localparam int          IDX_W       = 4;
    localparam int          CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/iopage_prio_enc.sv
// Combinational interrupt priority encoder.
// Ports:
//   req_i   - qualified request per slot (already filtered against cpu_pri)
//   ipl_i   - 3-bit request level per slot, slot i at [3i+2:3i]
//   found_o - at least one qualified request exists
//   idx_o   - winning slot: highest level, lowest index on a tie
//   ipl_o   - level of the winning slot
module iopage_prio_enc
    import iopage_bus_pkg::*;
#(
    parameter int NDEV = DEF_NDEV
) (
    input  logic [NDEV-1:0]   req_i,
    input  logic [3*NDEV-1:0] ipl_i,
    output logic              found_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [2:0]        ipl_o
);

    // Ascending scan with a strict greater-than keeps the lowest index
    // among slots that share the top level.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        ipl_o   = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (req_i[i] && (!found_o || (ipl_i[3*i +: 3] > ipl_o))) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
                ipl_o   = ipl_i[3*i +: 3];
            end
        end
    end

endmodule

// File: rtl/iopage_bus.sv
// I/O page bus glue: read-data mux, undecoded-access timeout, multiple
// decode error flag, and a non-preemptive interrupt arbiter that presents
// one device request at a time to the CPU.
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   iopage_rd/iopage_wr       - CPU I/O page strobes
//   dev_decode, dev_data_out  - per-slot address decode and read data
//   dev_interrupt, dev_ipl,
//   dev_vector                - per-slot interrupt request, level, vector
//   dev_interrupt_ack         - one-cycle grant pulse to the served slot
//   cpu_pri, ack_ipl          - CPU priority and one-hot acknowledge
//   data_out                  - combinational muxed read data
//   no_decode, decode_err     - timeout pulse and sticky multi-decode flag
//   interrupt, interrupt_ipl,
//   vector                    - presented request to the CPU
module iopage_bus
    import iopage_bus_pkg::*;
#(
    parameter int          NDEV         = DEF_NDEV,
    parameter int          TIMEOUT      = DEF_TIMEOUT,
    parameter logic [15:0] DEFAULT_DATA = DEF_DATA
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iopage_rd,
    input  logic               iopage_wr,
    input  logic [NDEV-1:0]    dev_decode,
    input  logic [16*NDEV-1:0] dev_data_out,
    input  logic [NDEV-1:0]    dev_interrupt,
    input  logic [3*NDEV-1:0]  dev_ipl,
    input  logic [8*NDEV-1:0]  dev_vector,
    output logic [NDEV-1:0]    dev_interrupt_ack,
    input  logic [2:0]         cpu_pri,
    input  logic [7:0]         ack_ipl,
    output logic [15:0]        data_out,
    output logic               no_decode,
    output logic               decode_err,
    output logic               interrupt,
    output logic [7:0]         interrupt_ipl,
    output logic [7:0]         vector
);

    logic             strobe;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             no_decode_q, no_decode_d;
    logic             decode_err_q, decode_err_d;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] win_idx_q, win_idx_d;
    logic [2:0]       win_ipl_q, win_ipl_d;
    logic [7:0]       win_vec_q, win_vec_d;
    logic             int_q, int_d;
    logic [7:0]       ipl_oh_q, ipl_oh_d;
    logic [7:0]       vec_q, vec_d;
    logic [NDEV-1:0]  ack_q, ack_d;

    logic [NDEV-1:0]  qual_req;
    logic             enc_found;
    logic [IDX_W-1:0] enc_idx;
    logic [2:0]       enc_ipl;
    logic [7:0]       enc_vec;
    logic             win_active;

    assign strobe = iopage_rd | iopage_wr;

    // Descending scan so the lowest-index decoding slot is written last.
    always_comb begin
        data_out = DEFAULT_DATA;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (dev_decode[i]) begin
                data_out = dev_data_out[16*i +: 16];
            end
        end
    end

    // The counter parks at TIMEOUT once past TIMEOUT-1, so a long strobe
    // gives a single no_decode pulse until it is released.
    always_comb begin
        cnt_d = '0;
        if (strobe && (dev_decode == '0)) begin
            cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        end
        no_decode_d  = (cnt_q == CNT_W'(TIMEOUT - 1));
        decode_err_d = decode_err_q | (strobe && ($countones(dev_decode) > 1));
    end

    // Only slots above the current CPU priority may compete.
    always_comb begin
        for (int i = 0; i < NDEV; i++) begin
            qual_req[i] = dev_interrupt[i] && (dev_ipl[3*i +: 3] > cpu_pri);
        end
    end

    iopage_prio_enc #(
        .NDEV    (NDEV)
    ) u_prio_enc (
        .req_i   (qual_req),
        .ipl_i   (dev_ipl),
        .found_o (enc_found),
        .idx_o   (enc_idx),
        .ipl_o   (enc_ipl)
    );

    // Slot lookups by index, written as loops so that NDEV below 16 never
    // produces an out-of-range select.
    always_comb begin
        enc_vec    = '0;
        win_active = 1'b0;
        for (int i = 0; i < NDEV; i++) begin
            if (IDX_W'(i) == enc_idx) begin
                enc_vec = dev_vector[8*i +: 8];
            end
            if (IDX_W'(i) == win_idx_q) begin
                win_active = dev_interrupt[i];
            end
        end
    end

    // Arbiter next state. Presentation outputs default to idle values and
    // are only reasserted while a request is being presented; the ack check
    // comes before the withdraw check so an ack always wins.
    always_comb begin
        state_d   = state_q;
        win_idx_d = win_idx_q;
        win_ipl_d = win_ipl_q;
        win_vec_d = win_vec_q;
        int_d     = 1'b0;
        ipl_oh_d  = '0;
        vec_d     = '0;
        ack_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (enc_found) begin
                    state_d   = ST_PRESENT;
                    win_idx_d = enc_idx;
                    win_ipl_d = enc_ipl;
                    win_vec_d = enc_vec;
                    int_d     = 1'b1;
                    ipl_oh_d  = 8'b1 << enc_ipl;
                    vec_d     = enc_vec;
                end
            end
            ST_PRESENT: begin
                if (ack_ipl[win_ipl_q]) begin
                    state_d = ST_RELEASE;
                    for (int i = 0; i < NDEV; i++) begin
                        if (IDX_W'(i) == win_idx_q) begin
                            ack_d[i] = 1'b1;
                        end
                    end
                end else if (!win_active || (cpu_pri >= win_ipl_q)) begin
                    state_d = ST_IDLE;
                end else begin
                    int_d    = 1'b1;
                    ipl_oh_d = 8'b1 << win_ipl_q;
                    vec_d    = win_vec_q;
                end
            end
            ST_RELEASE: begin
                if (!win_active) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            no_decode_q  <= 1'b0;
            decode_err_q <= 1'b0;
            state_q      <= ST_IDLE;
            win_idx_q    <= '0;
            win_ipl_q    <= '0;
            win_vec_q    <= '0;
            int_q        <= 1'b0;
            ipl_oh_q     <= '0;
            vec_q        <= '0;
            ack_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            no_decode_q  <= no_decode_d;
            decode_err_q <= decode_err_d;
            state_q      <= state_d;
            win_idx_q    <= win_idx_d;
            win_ipl_q    <= win_ipl_d;
            win_vec_q    <= win_vec_d;
            int_q        <= int_d;
            ipl_oh_q     <= ipl_oh_d;
            vec_q        <= vec_d;
            ack_q        <= ack_d;
        end
    end

    assign no_decode         = no_decode_q;
    assign decode_err        = decode_err_q;
    assign interrupt         = int_q;
    assign interrupt_ipl     = ipl_oh_q;
    assign vector            = vec_q;
    assign dev_interrupt_ack = ack_q;

endmodule

// File: tb/tb_iopage_bus.sv
// Self-checking bench for iopage_bus: a behavioural model updated on each
// rising edge is compared against every DUT output on each falling edge,
// and directed scenarios pin the model with hand-computed literal values.
module tb_iopage_bus;

    localparam int          NDEV         = 8;
    localparam int          TIMEOUT      = 4;
    localparam logic [15:0] DEFAULT_DATA = 16'hBEEF;

    logic               clk;
    logic               reset;
    logic               iopage_rd;
    logic               iopage_wr;
    logic [NDEV-1:0]    dev_decode;
    logic [16*NDEV-1:0] dev_data_out;
    logic [NDEV-1:0]    dev_interrupt;
    logic [3*NDEV-1:0]  dev_ipl;
    logic [8*NDEV-1:0]  dev_vector;
    logic [NDEV-1:0]    dev_interrupt_ack;
    logic [2:0]         cpu_pri;
    logic [7:0]         ack_ipl;
    logic [15:0]        data_out;
    logic               no_decode;
    logic               decode_err;
    logic               interrupt;
    logic [7:0]         interrupt_ipl;
    logic [7:0]         vector;

    iopage_bus #(
        .NDEV              (NDEV),
        .TIMEOUT           (TIMEOUT),
        .DEFAULT_DATA      (DEFAULT_DATA)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .iopage_rd         (iopage_rd),
        .iopage_wr         (iopage_wr),
        .dev_decode        (dev_decode),
        .dev_data_out      (dev_data_out),
        .dev_interrupt     (dev_interrupt),
        .dev_ipl           (dev_ipl),
        .dev_vector        (dev_vector),
        .dev_interrupt_ack (dev_interrupt_ack),
        .cpu_pri           (cpu_pri),
        .ack_ipl           (ack_ipl),
        .data_out          (data_out),
        .no_decode         (no_decode),
        .decode_err        (decode_err),
        .interrupt         (interrupt),
        .interrupt_ipl     (interrupt_ipl),
        .vector            (vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit checkEn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Model state: undecoded streak length, sticky error, and the arbiter
    // expressed as "which slot is being presented / awaiting release".
    int             streak = 0;
    bit             expNoDec = 1'b0;
    bit             expErr = 1'b0;
    bit             expInt = 1'b0;
    logic [7:0]     expIplOh = '0;
    logic [7:0]     expVec = '0;
    logic [NDEV-1:0] expAck = '0;
    int             mPhase = 0;
    int             mIdx = 0;
    int             mIpl = 0;

    function automatic logic [15:0] modelData();
        for (int i = 0; i < NDEV; i++) begin
            if (dev_decode[i]) return dev_data_out[16*i +: 16];
        end
        return DEFAULT_DATA;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            streak = 0; expNoDec = 0; expErr = 0; expInt = 0;
            expIplOh = '0; expVec = '0; expAck = '0; mPhase = 0;
        end else begin
            expNoDec = (streak == TIMEOUT - 1);
            if ((iopage_rd || iopage_wr) && (dev_decode == '0)) streak++;
            else streak = 0;
            if ((iopage_rd || iopage_wr) && ($countones(dev_decode) >= 2)) expErr = 1;
            expAck = '0;
            if (mPhase == 0) begin
                int best;
                int bestIpl;
                best = -1;
                bestIpl = 0;
                for (int i = 0; i < NDEV; i++) begin
                    if (dev_interrupt[i] && (int'(dev_ipl[3*i +: 3]) > int'(cpu_pri))
                        && (best < 0 || int'(dev_ipl[3*i +: 3]) > bestIpl)) begin
                        best = i;
                        bestIpl = int'(dev_ipl[3*i +: 3]);
                    end
                end
                if (best >= 0) begin
                    mPhase = 1; mIdx = best; mIpl = bestIpl;
                    expInt = 1; expIplOh = 8'(1 << bestIpl);
                    expVec = dev_vector[8*best +: 8];
                end else begin
                    expInt = 0; expIplOh = '0; expVec = '0;
                end
            end else if (mPhase == 1) begin
                if (ack_ipl[mIpl]) begin
                    expAck = NDEV'(1 << mIdx);
                    mPhase = 2;
                    expInt = 0; expIplOh = '0; expVec = '0;
                end else if (!dev_interrupt[mIdx] || int'(cpu_pri) >= mIpl) begin
                    mPhase = 0;
                    expInt = 0; expIplOh = '0; expVec = '0;
                end
            end else begin
                expInt = 0; expIplOh = '0; expVec = '0;
                if (!dev_interrupt[mIdx]) mPhase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model data_out", 32'(data_out), 32'(modelData()));
            checkOutput("model no_decode", 32'(no_decode), 32'(expNoDec));
            checkOutput("model decode_err", 32'(decode_err), 32'(expErr));
            checkOutput("model interrupt", 32'(interrupt), 32'(expInt));
            checkOutput("model interrupt_ipl", 32'(interrupt_ipl), 32'(expIplOh));
            checkOutput("model vector", 32'(vector), 32'(expVec));
            checkOutput("model ack", 32'(dev_interrupt_ack), 32'(expAck));
        end
    end

    // Sets the dynamic inputs now (2 time units after an edge or at time 0)
    // and lets the given number of rising edges pass.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [NDEV-1:0] dec,
                                 input logic [NDEV-1:0] irq, input logic [2:0] pri,
                                 input logic [7:0] ack, input int cycles);
        iopage_rd     = rd;
        iopage_wr     = wr;
        dev_decode    = dec;
        dev_interrupt = irq;
        cpu_pri       = pri;
        ack_ipl       = ack;
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    int pulses;
    int pulseAt;

    initial begin
        for (int i = 0; i < NDEV; i++) begin
            dev_data_out[16*i +: 16] = 16'h1000 + 16'(i * 16'h0111);
            dev_ipl[3*i +: 3]        = 3'd7;
            dev_vector[8*i +: 8]     = 8'(i * 4);
        end
        dev_data_out[32 +: 16] = 16'o173000;
        dev_ipl[0 +: 3] = 3'd4;  dev_vector[0 +: 8]  = 8'o060;
        dev_ipl[3 +: 3] = 3'd5;  dev_vector[8 +: 8]  = 8'o220;
        dev_ipl[6 +: 3] = 3'd4;  dev_vector[16 +: 8] = 8'o070;
        dev_ipl[9 +: 3] = 3'd6;  dev_vector[24 +: 8] = 8'o100;

        reset = 1'b1;
        applyStimulus(0, 0, '0, '0, 3'd0, 8'h00, 2);
        checkOutput("reset no_decode", 32'(no_decode), 32'd0);
        checkOutput("reset decode_err", 32'(decode_err), 32'd0);
        checkOutput("reset interrupt", 32'(interrupt), 32'd0);
        checkOutput("reset interrupt_ipl", 32'(interrupt_ipl), 32'd0);
        checkOutput("reset vector", 32'(vector), 32'd0);
        checkOutput("reset ack", 32'(dev_interrupt_ack), 32'd0);
        checkEn = 1'b1;
        reset = 1'b0;

        // Decoded read returns slot 2 data immediately, no timeout.
        applyStimulus(1, 0, 8'b0000_0100, '0, 3'd0, 8'h00, 0);
        #1 checkOutput("read slot2 data", 32'(data_out), 32'o173000);
        applyStimulus(1, 0, 8'b0000_0100, '0, 3'd0, 8'h00, 3);
        checkOutput("decoded read no_decode", 32'(no_decode), 32'd0);
        applyStimulus(0, 0, '0, '0, 3'd0, 8'h00, 0);
        #1 checkOutput("default data", 32'(data_out), 32'hBEEF);

        // Undecoded read held 6 cycles: one pulse, visible in cycle 5.
        for (int pass = 0; pass < 2; pass++) begin
            pulses = 0;
            pulseAt = -1;
            for (int c = 1; c <= 6; c++) begin
                applyStimulus(pass == 0, pass == 1, '0, '0, 3'd0, 8'h00, 1);
                if (no_decode) begin
                    pulses++;
                    pulseAt = c + 1;
                end
            end
            checkOutput("timeout pulse count", 32'(pulses), 32'd1);
            checkOutput("timeout pulse cycle", 32'(pulseAt), 32'd5);
            applyStimulus(0, 0, '0, '0, 3'd0, 8'h00, 1);
        end
        applyStimulus(1, 0, '0, '0, 3'd0, 8'h00, 2);
        applyStimulus(1, 0, 8'b0000_0001, '0, 3'd0, 8'h00, 3);
        checkOutput("early decode no pulse", 32'(no_decode), 32'd0);
        applyStimulus(0, 0, '0, '0, 3'd0, 8'h00, 1);

        // Slots 1 and 3 request: slot 3 (level 6) wins and is acked.
        applyStimulus(0, 0, '0, 8'b0000_1010, 3'd0, 8'h00, 1);
        checkOutput("arb interrupt", 32'(interrupt), 32'd1);
        checkOutput("arb vector", 32'(vector), 32'o100);
        checkOutput("arb ipl", 32'(interrupt_ipl), 32'h40);
        applyStimulus(0, 0, '0, 8'b0000_1010, 3'd0, 8'h40, 1);
        checkOutput("ack slot3", 32'(dev_interrupt_ack), 32'h08);
        checkOutput("release interrupt", 32'(interrupt), 32'd0);
        applyStimulus(0, 0, '0, 8'b0000_1010, 3'd0, 8'h00, 1);
        checkOutput("ack one cycle", 32'(dev_interrupt_ack), 32'h00);
        applyStimulus(0, 0, '0, 8'b0000_0010, 3'd0, 8'h00, 2);
        checkOutput("next vector", 32'(vector), 32'o220);
        checkOutput("next ipl", 32'(interrupt_ipl), 32'h20);
        // Wrong-level ack ignored; higher slot 3 does not preempt.
        applyStimulus(0, 0, '0, 8'b0000_1010, 3'd0, 8'h40, 2);
        checkOutput("no preempt vector", 32'(vector), 32'o220);
        checkOutput("wrong ack ignored", 32'(dev_interrupt_ack), 32'h00);
        applyStimulus(0, 0, '0, 8'b0000_1010, 3'd0, 8'h20, 1);
        checkOutput("ack slot1", 32'(dev_interrupt_ack), 32'h02);
        applyStimulus(0, 0, '0, '0, 3'd0, 8'h00, 2);

        // Equal levels masked by cpu_pri, then lowest index wins.
        applyStimulus(0, 0, '0, 8'b0000_0101, 3'd4, 8'h00, 2);
        checkOutput("masked interrupt", 32'(interrupt), 32'd0);
        applyStimulus(0, 0, '0, 8'b0000_0101, 3'd3, 8'h00, 1);
        checkOutput("tie vector", 32'(vector), 32'o060);
        checkOutput("tie ipl", 32'(interrupt_ipl), 32'h10);
        applyStimulus(0, 0, '0, 8'b0000_0101, 3'd4, 8'h00, 1);
        checkOutput("cpu_pri withdraw", 32'(interrupt), 32'd0);

        // Slot 0 withdraws its request before ack.
        applyStimulus(0, 0, '0, 8'b0000_0101, 3'd3, 8'h00, 1);
        checkOutput("slot0 presented", 32'(vector), 32'o060);
        applyStimulus(0, 0, '0, 8'b0000_0100, 3'd3, 8'h00, 1);
        checkOutput("withdraw interrupt", 32'(interrupt), 32'd0);
        checkOutput("withdraw no ack", 32'(dev_interrupt_ack), 32'h00);
        applyStimulus(0, 0, '0, '0, 3'd3, 8'h00, 2);

        // Double decode sets a sticky error.
        applyStimulus(1, 0, 8'b0000_0011, '0, 3'd0, 8'h00, 0);
        #1 checkOutput("double decode data", 32'(data_out), 32'h1000);
        applyStimulus(1, 0, 8'b0000_0011, '0, 3'd0, 8'h00, 1);
        checkOutput("decode_err set", 32'(decode_err), 32'd1);
        applyStimulus(0, 0, '0, '0, 3'd0, 8'h00, 3);
        checkOutput("decode_err sticky", 32'(decode_err), 32'd1);

        // Reset during presentation abandons the grant.
        applyStimulus(0, 0, '0, 8'b0000_1000, 3'd0, 8'h00, 1);
        checkOutput("pre-reset interrupt", 32'(interrupt), 32'd1);
        reset = 1'b1;
        applyStimulus(0, 0, '0, 8'b0000_1000, 3'd0, 8'h40, 1);
        checkOutput("reset-present interrupt", 32'(interrupt), 32'd0);
        checkOutput("reset-present ipl", 32'(interrupt_ipl), 32'd0);
        checkOutput("reset-present vector", 32'(vector), 32'd0);
        checkOutput("reset-present ack", 32'(dev_interrupt_ack), 32'd0);
        checkOutput("reset-present decode_err", 32'(decode_err), 32'd0);
        reset = 1'b0;
        applyStimulus(0, 0, '0, '0, 3'd0, 8'h00, 2);

        checkEn = 1'b0;
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
